pipe_latch: RTL and testbench

PIPE_LATCH -- requirements
Module: pipe_latch

---
 rtl/pipe_latch_pkg.sv | 22 ++
 rtl/pipe_latch_if.sv | 13 +
 rtl/pipe_sat_cnt.sv | 27 ++
 rtl/pipe_latch.sv | 93 +++++++++
 tb/tb_pipe_latch.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_latch_pkg.sv
// Shared pipeline definitions: stage state encoding and instruction field indices.
// Imported by the pipeline latch RTL and its bench.
package pipe_latch_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } pl_state_t;

   localparam int F_RD1     = 0;
   localparam int F_RD2     = 1;
   localparam int F_RS      = 2;
   localparam int F_RT      = 3;
   localparam int F_RD      = 4;
   localparam int F_SIGNIMM = 5;

   function automatic int field_lsb(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/pipe_latch_if.sv
// Valid/ready stage link carrying NFIELDS packed fields.
// Master drives valid and data, slave drives ready.
interface pipe_latch_if #(
   parameter int WIDTH   = 32,
   parameter int NFIELDS = 6
);
   logic                       valid;
   logic                       ready;
   logic [NFIELDS*WIDTH-1:0]   data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_sat_cnt.sv
// Saturating accumulator: adds a small increment when enabled, sticks at all-ones.
// Latency: result visible the cycle after en.
// Backpressure: none, accepts an increment every cycle.
module pipe_sat_cnt #(
   parameter int CNT_W = 16,
   parameter int INC_W = 2
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             en,
   input  logic [INC_W-1:0] inc,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W:0] sum;

   assign sum = {1'b0, cnt} + (CNT_W+1)'(inc);

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
      end
   end

endmodule

// File: rtl/pipe_latch.sv
// Two-entry pipeline stage register (MAIN + SKID) with flush and discard counter.
// Latency: 1 cycle in to out; full throughput while downstream is ready.
// Backpressure: in_ready drops only when both entries are held; ready/valid are pure state decodes.
module pipe_latch
   import pipe_latch_pkg::*;
#(
   parameter int WIDTH         = 32,
   parameter int NFIELDS       = 6,
   parameter bit ZERO_ON_FLUSH = 1'b1,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             flush,
   pipe_latch_if.slave      up,
   pipe_latch_if.master     dn,
   output logic [1:0]       occ,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int DW = NFIELDS * WIDTH;

   pl_state_t       st;
   logic [DW-1:0]   main_q;
   logic [DW-1:0]   skid_q;
   logic            xin;
   logic            xout;
   logic [1:0]      flush_inc;

   assign dn.valid = (st != EMPTY);
   assign up.ready = (st != FULL);
   assign dn.data  = main_q;
   assign occ      = st;

   assign xin  = up.valid & up.ready;
   assign xout = dn.valid & dn.ready;

   // A word leaving in the flush cycle was consumed, not discarded.
   assign flush_inc = occ - {1'b0, xout};

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         st     <= EMPTY;
         main_q <= '0;
         skid_q <= '0;
      end else if (flush) begin
         st <= EMPTY;
         if (ZERO_ON_FLUSH) begin
            main_q <= '0;
            skid_q <= '0;
         end
      end else begin
         case (st)
            EMPTY: begin
               if (up.valid) begin
                  main_q <= up.data;
                  st     <= ONE;
               end
            end
            ONE: begin
               case ({xin, xout})
                  2'b11: main_q <= up.data;
                  2'b10: begin
                     skid_q <= up.data;
                     st     <= FULL;
                  end
                  2'b01: st <= EMPTY;
                  default: ;
               endcase
            end
            FULL: begin
               if (dn.ready) begin
                  main_q <= skid_q;
                  st     <= ONE;
               end
            end
            default: st <= EMPTY;
         endcase
      end
   end

   pipe_sat_cnt #(
      .CNT_W (CNT_W),
      .INC_W (2)
   ) u_flush_cnt (
      .clk   (clk),
      .clr_n (clr_n),
      .en    (flush),
      .inc   (flush_inc),
      .cnt   (flush_cnt)
   );

endmodule

// File: tb/tb_pipe_latch.sv
// Bench for pipe_latch: directed scenarios plus random traffic against a queue model.
// Two instances share stimulus: default counter width and a 2-bit counter for saturation.
module tb_pipe_latch;
   import pipe_latch_pkg::*;

   localparam int WIDTH   = 32;
   localparam int NFIELDS = 6;
   localparam int DW      = WIDTH * NFIELDS;

   logic            clk = 1'b0;
   logic            clr_n = 1'b0;
   logic            flush = 1'b0;
   logic            in_valid = 1'b0;
   logic            out_ready = 1'b0;
   logic [DW-1:0]   in_data = '0;
   logic [1:0]      occ_a, occ_b;
   logic [15:0]     fcnt_a;
   logic [1:0]      fcnt_b;

   int n_vec = 0;
   int n_err = 0;

   logic [DW-1:0] q[$];
   logic [DW-1:0] last;
   int            cnt;

   always #5 clk = ~clk;

   pipe_latch_if #(.WIDTH(WIDTH), .NFIELDS(NFIELDS)) up_a ();
   pipe_latch_if #(.WIDTH(WIDTH), .NFIELDS(NFIELDS)) dn_a ();
   pipe_latch_if #(.WIDTH(WIDTH), .NFIELDS(NFIELDS)) up_b ();
   pipe_latch_if #(.WIDTH(WIDTH), .NFIELDS(NFIELDS)) dn_b ();

   assign up_a.valid = in_valid;
   assign up_a.data  = in_data;
   assign dn_a.ready = out_ready;
   assign up_b.valid = in_valid;
   assign up_b.data  = in_data;
   assign dn_b.ready = out_ready;

   pipe_latch #(.WIDTH(WIDTH), .NFIELDS(NFIELDS), .ZERO_ON_FLUSH(1'b1), .CNT_W(16)) dut (
      .clk       (clk),
      .clr_n     (clr_n),
      .flush     (flush),
      .up        (up_a),
      .dn        (dn_a),
      .occ       (occ_a),
      .flush_cnt (fcnt_a)
   );

   pipe_latch #(.WIDTH(WIDTH), .NFIELDS(NFIELDS), .ZERO_ON_FLUSH(1'b1), .CNT_W(2)) dut_s (
      .clk       (clk),
      .clr_n     (clr_n),
      .flush     (flush),
      .up        (up_b),
      .dn        (dn_b),
      .occ       (occ_b),
      .flush_cnt (fcnt_b)
   );

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] word(input logic [31:0] f0);
      logic [DW-1:0] w;
      w = '0;
      w[field_lsb(F_RD1, WIDTH) +: WIDTH] = f0;
      w[field_lsb(F_SIGNIMM, WIDTH) +: WIDTH] = ~f0;
      return w;
   endfunction

   function automatic logic [DW-1:0] rand_word();
      logic [DW-1:0] w;
      for (int f = 0; f < NFIELDS; f++) w[f*WIDTH +: WIDTH] = $urandom;
      return w;
   endfunction

   task automatic check_all(input string tag);
      int sz;
      sz = q.size();
      chk({tag, ".out_valid"}, dn_a.valid, (sz > 0));
      chk({tag, ".in_ready"},  up_a.ready, (sz < 2));
      chk({tag, ".occ"},       occ_a, sz);
      chk({tag, ".out_data"},  dn_a.data, (sz > 0) ? q[0] : last);
      chk({tag, ".flush_cnt"}, fcnt_a, (cnt > 65535) ? 65535 : cnt);
      chk({tag, ".flush_cnt_sat"}, fcnt_b, (cnt > 3) ? 3 : cnt);
      chk({tag, ".occ_sat"},   occ_b, sz);
   endtask

   task automatic model_reset();
      q.delete();
      last = '0;
      cnt  = 0;
   endtask

   task automatic cyc(input string tag, input logic iv, input logic [DW-1:0] d,
                      input logic ordy, input logic fl);
      bit xin, xout;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      @(posedge clk);
      xin  = iv && (q.size() < 2);
      xout = (q.size() > 0) && ordy;
      if (fl) begin
         cnt += q.size() - (xout ? 1 : 0);
         q.delete();
         last = '0;
      end else begin
         if (xout) last = q.pop_front();
         if (xin) q.push_back(d);
      end
      #1;
      check_all(tag);
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      flush     = 1'b0;
      clr_n     = 1'b0;
      model_reset();
      #1;
      check_all("reset");
      @(negedge clk);
      clr_n = 1'b1;
   endtask

   initial begin
      model_reset();
      #3;
      do_reset();

      // streaming
      for (int k = 1; k <= 4; k++) begin
         cyc("stream", 1'b1, word(k), 1'b1, 1'b0);
         chk("stream.field0", dn_a.data[WIDTH-1:0], k);
         chk("stream.occ1", occ_a, 2'd1);
      end
      cyc("stream_drain", 1'b0, '0, 1'b1, 1'b0);

      // stall with skid capture
      cyc("stall_a", 1'b1, word(32'hA), 1'b1, 1'b0);
      chk("stall.A_out", dn_a.data[WIDTH-1:0], 32'hA);
      cyc("stall_b", 1'b1, word(32'hB), 1'b0, 1'b0);
      cyc("stall_c1", 1'b1, word(32'hC), 1'b0, 1'b0);
      cyc("stall_c2", 1'b1, word(32'hC), 1'b0, 1'b0);
      chk("stall.occ2", occ_a, 2'd2);
      chk("stall.in_ready0", up_a.ready, 1'b0);
      chk("stall.A_held", dn_a.data[WIDTH-1:0], 32'hA);
      cyc("resume1", 1'b1, word(32'hC), 1'b1, 1'b0);
      chk("resume.B_out", dn_a.data[WIDTH-1:0], 32'hB);
      cyc("resume2", 1'b1, word(32'hC), 1'b1, 1'b0);
      chk("resume.C_out", dn_a.data[WIDTH-1:0], 32'hC);
      cyc("resume3", 1'b0, '0, 1'b1, 1'b0);
      chk("resume.empty", dn_a.valid, 1'b0);

      // flush while FULL
      cyc("ff_load1", 1'b1, word(32'h11), 1'b0, 1'b0);
      cyc("ff_load2", 1'b1, word(32'h22), 1'b0, 1'b0);
      cyc("ff_flush", 1'b1, word(32'h33), 1'b0, 1'b1);
      chk("flush.occ0", occ_a, 2'd0);
      chk("flush.valid0", dn_a.valid, 1'b0);
      chk("flush.data0", dn_a.data, '0);
      chk("flush.cnt2", fcnt_a, 16'd2);
      cyc("ff_after", 1'b0, '0, 1'b1, 1'b0);
      chk("flush.dropped", dn_a.valid, 1'b0);

      // saturation on the 2-bit counter
      do_reset();
      for (int k = 0; k < 3; k++) begin
         cyc("sat_load", 1'b1, word(32'h50 + k), 1'b0, 1'b0);
         cyc("sat_flush", 1'b0, '0, 1'b0, 1'b1);
      end
      chk("sat.cnt3", fcnt_b, 2'd3);
      cyc("sat_full1", 1'b1, word(32'h61), 1'b0, 1'b0);
      cyc("sat_full2", 1'b1, word(32'h62), 1'b0, 1'b0);
      cyc("sat_flush_full", 1'b0, '0, 1'b0, 1'b1);
      chk("sat.cnt_stuck", fcnt_b, 2'd3);
      chk("sat.cnt_wide5", fcnt_a, 16'd5);

      // asynchronous reset while FULL
      cyc("ar_load1", 1'b1, word(32'h71), 1'b0, 1'b0);
      cyc("ar_load2", 1'b1, word(32'h72), 1'b0, 1'b0);
      @(negedge clk);
      clr_n = 1'b0;
      #1;
      chk("areset.valid0", dn_a.valid, 1'b0);
      chk("areset.ready1", up_a.ready, 1'b1);
      chk("areset.cnt0", fcnt_a, 16'd0);
      chk("areset.data0", dn_a.data, '0);
      do_reset();

      // random traffic with rare flushes
      for (int i = 0; i < 10000; i++) begin
         cyc("rand", 1'($urandom_range(0, 1)), rand_word(), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 63) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
